m6809_core_pullseq: RTL

Byte sequencer for the 6809 PULS/PULU instructions. It walks the post-byte register mask in pull order and issues one memory read per byte at the current stack pointer. Each completed register value goes out on a register write port, and the final stack pointer is written back. It sits between the instruction decoder and the register file, and is the read-side counterpart of the push/transfer register-move path.

---
 rtl/m6809_core_pullseq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/m6809_core_pullseq.sv
// PULS/PULU byte sequencer: walks the post-byte mask lowest bit first, reading
// one byte per RD/CAP pair, writing completed registers and the final stack pointer.
module m6809_core_pullseq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  postbyte,
  input  logic        use_u,
  input  logic [15:0] sp_in,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic        rd,
  output logic        reg_we,
  output logic [3:0]  reg_sel,
  output logic [15:0] reg_data,
  output logic        sp_we,
  output logic [15:0] sp_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MASK_W = 8;
  localparam int unsigned PTR_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [MASK_W-1:0]  r_mask,  w_mask_nxt;
  logic               r_use_u, w_use_u_nxt;
  logic [PTR_W-1:0]   r_ptr,   w_ptr_nxt;
  logic [7:0]         r_hold,  w_hold_nxt;
  logic               r_lo,    w_lo_nxt;

  logic [IDX_W-1:0]   w_idx;
  logic               w_is16;
  logic [SEL_W-1:0]   w_code;
  logic [MASK_W-1:0]  w_mask_clr;

  // Lowest set mask bit is the next register in pull order.
  always_comb begin
    w_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (r_mask[i]) w_idx = IDX_W'(i);
    end
  end

  assign w_is16     = w_idx[2];
  assign w_mask_clr = r_mask & ~(MASK_W'(1) << w_idx);

  // Bit 6 names the stack the instruction is not using.
  always_comb begin
    w_code = '0;
    case (w_idx)
      3'd0:    w_code = 4'hA;
      3'd1:    w_code = 4'h8;
      3'd2:    w_code = 4'h9;
      3'd3:    w_code = 4'hB;
      3'd4:    w_code = 4'h1;
      3'd5:    w_code = 4'h2;
      3'd6:    w_code = r_use_u ? 4'h4 : 4'h3;
      default: w_code = 4'h5;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_use_u <= 1'b0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_lo    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_use_u <= w_use_u_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // Next state plus outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_use_u_nxt = r_use_u;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_lo_nxt    = r_lo;
    addr        = '0;
    rd          = 1'b0;
    reg_we      = 1'b0;
    reg_sel     = '0;
    reg_data    = '0;
    sp_we       = 1'b0;
    sp_out      = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mask_nxt  = postbyte;
          w_use_u_nxt = use_u;
          w_ptr_nxt   = sp_in;
          w_hold_nxt  = '0;
          w_lo_nxt    = 1'b0;
          w_state_nxt = (postbyte != '0) ? S_RD : S_FIN;
        end
      end
      S_RD: begin
        busy        = 1'b1;
        rd          = 1'b1;
        addr        = r_ptr;
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        busy      = 1'b1;
        w_ptr_nxt = r_ptr + PTR_W'(1);
        if (w_is16 && !r_lo) begin
          w_hold_nxt  = din;
          w_lo_nxt    = 1'b1;
          w_state_nxt = S_RD;
        end else begin
          reg_we      = 1'b1;
          reg_sel     = w_code;
          reg_data    = w_is16 ? {r_hold, din} : {8'h00, din};
          w_mask_nxt  = w_mask_clr;
          w_lo_nxt    = 1'b0;
          w_state_nxt = (w_mask_clr != '0) ? S_RD : S_FIN;
        end
      end
      S_FIN: begin
        busy        = 1'b1;
        sp_we       = 1'b1;
        sp_out      = r_ptr;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
